alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequences the shared 8-bit ALU/prefix-adder datapath from a narrow byte port.
//  Loads operand A, then B, over one 8-bit handshake bus and drives registered, stable
//  A/B/sel/Cin into the ALU for EXEC_CYCLES cycles. It then captures R and Cout and
//  holds them until acknowledged. Chain mode reuses the last result/carry as A/Cin,
//  which gives multi-byte accumulate. Sits between the tt_um top-level pins and the ALU.
// PARAMETERS
//  W            8   operand/result width
//  SEL_W        3   ALU select width
//  EXEC_CYCLES  1   cycles ALU inputs held stable before capture (legal 1..15)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  ena        in   1      0: every register frozen (state, timer, outputs); handshakes stall
//  din        in   W      operand byte
//  din_valid  in   1      din carries a byte
//  din_ready  out  1      sequencer accepts a byte this cycle
//  op_sel     in   SEL_W  ALU op, sampled with first byte (A, or B in chain)
//  cin_in     in   1      carry-in, sampled with A byte (ignored in chain)
//  chain      in   1      sampled with first byte: 1 = byte is B; A/Cin = last result/cout
//  alu_a      out  W      registered ALU operand A
//  alu_b      out  W      registered ALU operand B
//  alu_sel    out  SEL_W  registered ALU select
//  alu_cin    out  1      registered carry-in to prefix adder
//  alu_r      in   W      ALU result (combinational from alu_* outputs)
//  alu_cout   in   1      prefix-adder carry-out
//  res        out  W      captured result
//  res_cout   out  1      captured carry-out
//  res_valid  out  1      res/res_cout valid, held until res_ack
//  res_ack    in   1      consumer takes result
//  busy       out  1      state != IDLE
//  op_count   out  8      completed operations, wraps 255->0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except din_ready=1; last result/cout regs=0.
//  Byte transfer: din_valid & din_ready & ena. din_ready=1 only in IDLE and GET_B.
//  FSM: IDLE -> GET_B : transfer, chain=0; alu_a<=din, alu_sel<=op_sel, alu_cin<=cin_in.
//       IDLE -> EXEC  : transfer, chain=1; alu_b<=din, alu_a<=res, alu_cin<=res_cout,
//                       alu_sel<=op_sel. After reset, chain uses A=0, Cin=0.
//       GET_B -> EXEC : transfer; alu_b<=din.
//       EXEC          : timer counts EXEC_CYCLES cycles. Last cycle -> DONE; res<=alu_r,
//                       res_cout<=alu_cout, op_count++.
//       DONE -> IDLE  : res_ack & ena. res_valid=1 throughout DONE, 0 elsewhere.
//  Latency: B (or chain) byte on edge m. EXEC occupies m+1..m+EXEC_CYCLES.
//   res_valid first asserts at cycle m+EXEC_CYCLES+1. Ack in DONE -> IDLE next edge.
//  alu_* change only on byte transfers and hold otherwise, incl. EXEC/DONE/IDLE.
//  res/res_cout hold after ack until the next capture (chain source).
//  Arithmetic: no arithmetic here; op_count is modulo 256.
//  Boundaries:
//   res_ack outside DONE is ignored. din_valid in EXEC/DONE is ignored (ready=0, byte not consumed).
//   ena=0 mid-EXEC pauses the timer; capture still occurs after EXEC_CYCLES enabled cycles.
//   rst_n low at any point, incl. mid-EXEC, aborts the op and returns all regs to reset values.
//   chain, op_sel and cin_in are don't-care except on the first-byte transfer.
// STRUCTURE
//  Package alu_seq_pkg: state enum {IDLE,GET_B,EXEC,DONE}, W/SEL_W defaults, timer width.
//  Sub-module alu_seq_timer: loadable down-counter with ena gating and done pulse.
//  Top: FSM, operand/result regs, op_count. ALU and Prefix instances stay outside.
// TESTING (bench ALU model: sel=000 -> R=A+B+Cin, Cout = carry)
//  A=0x12,cin=0,sel=000 then B=0x05, EXEC_CYCLES=1 -> res_valid 2 cycles after B; res=0x17,cout=0
//  A=0xFF,cin=1 then B=0x01 -> res=0x01,cout=1; chain B=0x00 -> alu_a=0x01,cin=1; res=0x02,cout=0
//  Hold res_ack=0 for 10 cycles in DONE, din_valid=1 -> din_ready=0, res stable; ack -> IDLE, busy=0
//  EXEC_CYCLES=4, ena low 3 cycles mid-EXEC -> capture delayed exactly 3 cycles; value unchanged
//  rst_n low during EXEC -> all outputs reset, op_count=0; next op completes normally
//  256 back-to-back ops -> op_count wraps to 0; chain after reset -> A=0,Cin=0

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU operand sequencer.
package alu_seq_pkg;

  localparam int unsigned DefW    = 8;
  localparam int unsigned DefSelW = 3;
  localparam int unsigned TimerW  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StGetB,
    StExec,
    StDone
  } state_e;

endpackage

// File: rtl/alu_seq_timer.sv
// Loadable down-counter that times how long the ALU inputs are held stable.
module alu_seq_timer
  import alu_seq_pkg::*;
#(
  parameter int unsigned TW = TimerW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          run,
  output logic          done
);

  logic [TW-1:0] r_count;

  // Pulses on the last enabled cycle of the run, so ena=0 stretches the window.
  assign done = run & ena & (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (ena) begin
      if (load) begin
        r_count <= load_val;
      end else if (run && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A/B over a byte handshake, holds them on the ALU for EXEC_CYCLES, captures R/Cout.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned W           = DefW,
  parameter int unsigned SEL_W       = DefSelW,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [SEL_W-1:0] op_sel,
  input  logic             cin_in,
  input  logic             chain,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic             alu_cin,
  input  logic [W-1:0]     alu_r,
  input  logic             alu_cout,
  output logic [W-1:0]     res,
  output logic             res_cout,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy,
  output logic [7:0]       op_count
);

  state_e           r_state;
  state_e           w_state_next;
  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  logic             r_alu_cin;
  logic [W-1:0]     r_res;
  logic             r_res_cout;
  logic [7:0]       r_op_count;
  logic             w_xfer;
  logic             w_load;
  logic             w_timer_done;

  assign din_ready = (r_state == StIdle) || (r_state == StGetB);
  assign w_xfer    = din_valid & din_ready & ena;
  // The timer is armed on whichever byte completes the operand pair.
  assign w_load    = w_xfer & ((r_state == StGetB) || ((r_state == StIdle) && chain));

  alu_seq_timer #(
    .TW(TimerW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .load    (w_load),
    .load_val(TimerW'(EXEC_CYCLES - 1)),
    .run     (r_state == StExec),
    .done    (w_timer_done)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_xfer) w_state_next = chain ? StExec : StGetB;
      StGetB:  if (w_xfer) w_state_next = StExec;
      StExec:  if (w_timer_done) w_state_next = StDone;
      StDone:  if (res_ack && ena) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_alu_cin  <= 1'b0;
      r_res      <= '0;
      r_res_cout <= 1'b0;
      r_op_count <= '0;
    end else if (ena) begin
      if (w_xfer && (r_state == StIdle)) begin
        r_alu_sel <= op_sel;
        if (chain) begin
          // Chain: previous result and carry become A/Cin for multi-byte accumulate.
          r_alu_b   <= din;
          r_alu_a   <= r_res;
          r_alu_cin <= r_res_cout;
        end else begin
          r_alu_a   <= din;
          r_alu_cin <= cin_in;
        end
      end
      if (w_xfer && (r_state == StGetB)) begin
        r_alu_b <= din;
      end
      if (w_timer_done) begin
        r_res      <= alu_r;
        r_res_cout <= alu_cout;
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign alu_cin   = r_alu_cin;
  assign res       = r_res;
  assign res_cout  = r_res_cout;
  assign res_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU on the alu_* pins.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [2:0] op_sel;
  logic       cin_in;
  logic       chain;
  logic [7:0] alu_a, alu_b, alu_r;
  logic [2:0] alu_sel;
  logic       alu_cin, alu_cout;
  logic [7:0] res;
  logic       res_cout, res_valid, res_ack, busy;
  logic [7:0] op_count;

  // Second instance with EXEC_CYCLES=4 for the enable-pause scenario.
  logic       d4_ena, d4_din_valid, d4_din_ready, d4_chain, d4_cin_in, d4_res_ack;
  logic [7:0] d4_din;
  logic [2:0] d4_op_sel;
  logic [7:0] d4_alu_a, d4_alu_b, d4_alu_r, d4_res, d4_op_count;
  logic [2:0] d4_alu_sel;
  logic       d4_alu_cin, d4_alu_cout, d4_res_cout, d4_res_valid, d4_busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb_q[$];
  logic [7:0] m_a, m_res, m_count;
  logic [2:0] m_sel;
  logic       m_cin, m_cout;

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] s, input logic c);
    case (s)
      3'b000:  return {1'b0, a} + {1'b0, b} + {8'd0, c};
      3'b001:  return {1'b0, a & b};
      3'b010:  return {1'b0, a | b};
      3'b011:  return {1'b0, a ^ b};
      default: return {1'b0, a} + {1'b0, ~b} + {8'd0, c};
    endcase
  endfunction

  assign {alu_cout, alu_r}       = alu_model(alu_a, alu_b, alu_sel, alu_cin);
  assign {d4_alu_cout, d4_alu_r} = alu_model(d4_alu_a, d4_alu_b, d4_alu_sel, d4_alu_cin);

  alu_op_sequencer #(.W(8), .SEL_W(3), .EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .op_sel(op_sel), .cin_in(cin_in), .chain(chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_r(alu_r), .alu_cout(alu_cout), .res(res), .res_cout(res_cout),
    .res_valid(res_valid), .res_ack(res_ack), .busy(busy), .op_count(op_count)
  );

  alu_op_sequencer #(.W(8), .SEL_W(3), .EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(d4_ena), .din(d4_din), .din_valid(d4_din_valid),
    .din_ready(d4_din_ready), .op_sel(d4_op_sel), .cin_in(d4_cin_in), .chain(d4_chain),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel), .alu_cin(d4_alu_cin),
    .alu_r(d4_alu_r), .alu_cout(d4_alu_cout), .res(d4_res), .res_cout(d4_res_cout),
    .res_valid(d4_res_valid), .res_ack(d4_res_ack), .busy(d4_busy), .op_count(d4_op_count)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] d, input logic [2:0] s, input logic c,
                           input logic ch);
    din = d; op_sel = s; cin_in = c; chain = ch; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; chain = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] a, input logic [2:0] s, input logic c);
    m_a = a; m_sel = s; m_cin = c;
    send_byte(a, s, c, 1'b0);
  endtask

  // op_sel/cin driven with junk on the B byte: they must be ignored there.
  task automatic send_b(input logic [7:0] b);
    sb_q.push_back(alu_model(m_a, b, m_sel, m_cin));
    send_byte(b, ~m_sel, ~m_cin, 1'b0);
  endtask

  task automatic send_chain(input logic [7:0] b, input logic [2:0] s);
    m_a = m_res; m_cin = m_cout; m_sel = s;
    sb_q.push_back(alu_model(m_a, b, m_sel, m_cin));
    send_byte(b, s, ~m_cout, 1'b1);
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic pop_expect(output logic [8:0] e);
    if (sb_q.size() == 0) begin
      e = 'x;
    end else begin
      e = sb_q.pop_front();
      m_res = e[7:0]; m_cout = e[8]; m_count = m_count + 8'd1;
    end
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    m_res = '0; m_cout = 1'b0; m_count = '0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({alu_a, alu_b, alu_sel, alu_cin, res, res_cout, res_valid, busy, op_count, din_ready}
        !== {8'd0, 8'd0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h sel=%h cin=%b res=%h cout=%b v=%b busy=%b cnt=%h rdy=%b want all 0, rdy=1",
               alu_a, alu_b, alu_sel, alu_cin, res, res_cout, res_valid, busy, op_count, din_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int         cyc;
    logic [8:0] e;
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
    n_tests++;
    if ({busy, op_count} !== {1'b0, m_count}) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: got busy=%b cnt=%h want busy=0 cnt=%h", busy, op_count,
               m_count);
    end
    send_a(8'h12, 3'b000, 1'b0);
    send_b(8'h05);
    n_tests++;
    if ({alu_a, alu_b, alu_sel, alu_cin, busy, res_valid, din_ready}
        !== {8'h12, 8'h05, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_operands: got a=%h b=%h sel=%h cin=%b busy=%b v=%b rdy=%b want 12 05 0 0 1 0 0",
               alu_a, alu_b, alu_sel, alu_cin, busy, res_valid, din_ready);
    end
    wait_res(cyc);
    n_tests++;
    if (cyc !== 1) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges want 1", cyc);
    end
    pop_expect(e);
    n_tests++;
    if ({res_cout, res, op_count} !== {e, m_count}) begin
      n_fail++;
      $display("FAIL basic_result: got cout=%b res=%h cnt=%h want cout=%b res=%h cnt=%h",
               res_cout, res, op_count, e[8], e[7:0], m_count);
    end
    do_ack();
    n_tests++;
    if ({busy, res_valid, res_cout, res} !== {1'b0, 1'b0, e}) begin
      n_fail++;
      $display("FAIL basic_ack: got busy=%b v=%b res=%h want 0 0 %h", busy, res_valid, res,
               e[7:0]);
    end
  endtask

  task automatic test_chain();
    int         cyc;
    logic [8:0] e;
    send_a(8'hFF, 3'b000, 1'b1);
    send_b(8'h01);
    wait_res(cyc);
    pop_expect(e);
    n_tests++;
    if ({res_cout, res} !== {1'b1, 8'h01} || cyc >= 50) begin
      n_fail++;
      $display("FAIL chain_first: got cout=%b res=%h want cout=1 res=01", res_cout, res);
    end
    do_ack();
    send_chain(8'h00, 3'b000);
    n_tests++;
    if ({alu_a, alu_b, alu_cin, busy} !== {m_a, 8'h00, m_cin, 1'b1}) begin
      n_fail++;
      $display("FAIL chain_operands: got a=%h b=%h cin=%b busy=%b want a=%h b=00 cin=%b busy=1",
               alu_a, alu_b, alu_cin, busy, m_a, m_cin);
    end
    wait_res(cyc);
    pop_expect(e);
    n_tests++;
    if ({res_cout, res} !== {1'b0, 8'h02} || cyc !== 1) begin
      n_fail++;
      $display("FAIL chain_result: got cout=%b res=%h lat=%0d want cout=0 res=02 lat=1",
               res_cout, res, cyc);
    end
    do_ack();
  endtask

  task automatic test_hold_done();
    int         cyc;
    logic [8:0] e;
    send_a(8'h3C, 3'b011, 1'b0);
    send_b(8'hA5);
    wait_res(cyc);
    pop_expect(e);
    din = 8'h55; din_valid = 1'b1; chain = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({din_ready, res_valid, res_cout, res, alu_a, alu_b} !== {1'b0, 1'b1, e, 8'h3C, 8'hA5})
      begin
        n_fail++;
        $display("FAIL done_hold[%0d]: got rdy=%b v=%b res=%h a=%h b=%h want 0 1 %h 3c a5",
                 i, din_ready, res_valid, res, alu_a, alu_b, e[7:0]);
      end
    end
    din_valid = 1'b0; chain = 1'b0;
    do_ack();
    n_tests++;
    if ({busy, res_valid, din_ready, op_count} !== {1'b0, 1'b0, 1'b1, m_count}) begin
      n_fail++;
      $display("FAIL done_ack: got busy=%b v=%b rdy=%b cnt=%h want 0 0 1 %h", busy, res_valid,
               din_ready, op_count, m_count);
    end
  endtask

  task automatic test_ena_pause();
    int         cyc;
    logic [8:0] e;
    e = alu_model(8'h80, 8'h90, 3'b000, 1'b1);
    d4_din = 8'h80; d4_op_sel = 3'b000; d4_cin_in = 1'b1; d4_din_valid = 1'b1;
    @(posedge clk); #1;
    d4_din = 8'h90;
    @(posedge clk); #1;
    d4_din_valid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    d4_ena = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      cyc++;
    end
    d4_ena = 1'b1;
    while (!d4_res_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (cyc !== 7) begin
      n_fail++;
      $display("FAIL ena_pause_latency: got %0d edges want 7", cyc);
    end
    n_tests++;
    if ({d4_res_cout, d4_res, d4_op_count} !== {e, 8'd1}) begin
      n_fail++;
      $display("FAIL ena_pause_result: got cout=%b res=%h cnt=%h want cout=%b res=%h cnt=01",
               d4_res_cout, d4_res, d4_op_count, e[8], e[7:0]);
    end
    d4_res_ack = 1'b1;
    @(posedge clk); #1;
    d4_res_ack = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    int         cyc;
    logic [8:0] e;
    send_a(8'h77, 3'b001, 1'b1);
    send_b(8'h0F);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({alu_a, alu_b, alu_sel, alu_cin, res, res_cout, res_valid, busy, op_count, din_ready}
        !== {8'd0, 8'd0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_exec: got a=%h b=%h res=%h v=%b busy=%b cnt=%h rdy=%b want 0s rdy=1",
               alu_a, alu_b, res, res_valid, busy, op_count, din_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    m_res = '0; m_cout = 1'b0; m_count = '0;
    send_a(8'h30, 3'b000, 1'b1);
    send_b(8'h40);
    wait_res(cyc);
    pop_expect(e);
    n_tests++;
    if ({res_cout, res, op_count} !== {1'b0, 8'h71, 8'd1} || cyc !== 1) begin
      n_fail++;
      $display("FAIL post_reset_op: got cout=%b res=%h cnt=%h lat=%0d want 0 71 01 1",
               res_cout, res, op_count, cyc);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int         cyc;
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i % 3 == 2) begin
        send_chain(8'($urandom), 3'($urandom));
      end else begin
        send_a(8'($urandom), 3'($urandom), 1'($urandom));
        send_b(8'($urandom));
      end
      wait_res(cyc);
      pop_expect(e);
      n_tests++;
      if ({res_cout, res, op_count} !== {e, m_count} || cyc !== 1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got cout=%b res=%h cnt=%h lat=%0d want %b %h %h 1", i,
                 res_cout, res, op_count, cyc, e[8], e[7:0], m_count);
      end
      do_ack();
    end
    n_tests++;
    if (op_count !== 8'd0) begin
      n_fail++;
      $display("FAIL op_count_wrap: got %h want 00", op_count);
    end
  endtask

  task automatic test_chain_after_reset();
    int         cyc;
    logic [8:0] e;
    do_reset();
    send_chain(8'h05, 3'b000);
    n_tests++;
    if ({alu_a, alu_cin, alu_b} !== {8'h00, 1'b0, 8'h05}) begin
      n_fail++;
      $display("FAIL chain_after_reset: got a=%h cin=%b b=%h want a=00 cin=0 b=05", alu_a,
               alu_cin, alu_b);
    end
    wait_res(cyc);
    pop_expect(e);
    n_tests++;
    if ({res_cout, res} !== {1'b0, 8'h05} || cyc !== 1) begin
      n_fail++;
      $display("FAIL chain_after_reset_res: got cout=%b res=%h lat=%0d want 0 05 1", res_cout,
               res, cyc);
    end
    do_ack();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; ena = 1'b1;
    din = '0; din_valid = 1'b0; op_sel = '0; cin_in = 1'b0; chain = 1'b0; res_ack = 1'b0;
    d4_ena = 1'b1; d4_din = '0; d4_din_valid = 1'b0; d4_op_sel = '0; d4_cin_in = 1'b0;
    d4_chain = 1'b0; d4_res_ack = 1'b0;
    m_a = '0; m_sel = '0; m_cin = 1'b0; m_res = '0; m_cout = 1'b0; m_count = '0;
    #12;
    test_reset();
    test_basic();
    test_chain();
    test_hold_done();
    test_ena_pause();
    test_reset_mid_exec();
    test_back_to_back();
    test_chain_after_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
